// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
//
// Serial parity checker for a framed bit stream. Each frame is DATA_BITS data
// bits followed by a single parity bit. Running parity of the data bits is
// kept while the frame arrives. The parity bit is then checked against the
// selected odd/even mode. A saturating counter records how many frames failed.
//
// Parameters
//   DATA_BITS  data bits per frame, excluding the parity bit (>= 1)
//   CNT_W      width of the saturating error counter (>= 1)
//   IDX_W      derived width of bit_idx
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   x_in        serial data bit, used only when x_valid=1
//   x_valid     qualifies x_in for this cycle
//   sync        synchronous frame restart; drops any partial frame
//   par_mode    0 = even parity, 1 = odd parity; sampled with the parity bit
//   err_clr     synchronous clear of err_cnt
//   odd_out     running parity of data bits accepted this frame (1 = odd)
//   bit_idx     index of next expected bit (DATA_BITS means the parity bit)
//   frame_done  one-cycle pulse after the parity bit is accepted
//   par_err     one-cycle pulse with frame_done when parity mismatches
//   frame_par   data parity of the last completed frame
//   err_cnt     saturating count of frames with a parity error
// -----------------------------------------------------------------------------
module parity_frame_checker #(
  parameter  int DATA_BITS = 8,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = $clog2(DATA_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             sync,
  input  logic             par_mode,
  input  logic             err_clr,
  output logic             odd_out,
  output logic [IDX_W-1:0] bit_idx,
  output logic             frame_done,
  output logic             par_err,
  output logic             frame_par,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] PAR_IDX       = IDX_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             odd_q, odd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;
  logic             fpar_q, fpar_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DATA;
      odd_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      fpar_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      fpar_q  <= fpar_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame sequencing. sync takes priority over everything, including a
  // parity bit arriving in the same cycle, so a restart never reports a frame.
  always_comb begin
    state_d   = state_q;
    odd_d     = odd_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    fpar_d    = fpar_q;
    frame_err = 1'b0;

    if (sync) begin
      state_d = ST_DATA;
      odd_d   = 1'b0;
      idx_d   = '0;
    end else if (x_valid) begin
      case (state_q)
        ST_DATA: begin
          odd_d = odd_q ^ x_in;
          if (idx_q == LAST_DATA_IDX) begin
            state_d = ST_PAR;
            idx_d   = PAR_IDX;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_PAR: begin
          // Parity bit is compared, never folded into the running parity.
          frame_err = ((odd_q ^ x_in) != par_mode);
          done_d    = 1'b1;
          perr_d    = frame_err;
          fpar_d    = odd_q;
          odd_d     = 1'b0;
          idx_d     = '0;
          state_d   = ST_DATA;
        end
        default: begin
          state_d = ST_DATA;
          odd_d   = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Error counter: a clear coinciding with a failing frame leaves one error
  // recorded rather than losing it.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = frame_err ? CNT_W'(1) : '0;
    end else if (frame_err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign odd_out    = odd_q;
  assign bit_idx    = idx_q;
  assign frame_done = done_q;
  assign par_err    = perr_q;
  assign frame_par  = fpar_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_checker
//
// Directed bench for parity_frame_checker. One instance uses the default
// 8-bit frames with an 8-bit counter; a second uses DATA_BITS=1 and CNT_W=2
// to exercise counter saturation and the shortest frame length.
// Inputs change on the falling edge and outputs are read on the next falling
// edge, i.e. after the rising edge that consumed the inputs.
// -----------------------------------------------------------------------------
module tb_parity_frame_checker;

  logic       clk;
  logic       rst;

  logic       x_in, x_valid, sync, par_mode, err_clr;
  logic       odd_out, frame_done, par_err, frame_par;
  logic [3:0] bit_idx;
  logic [7:0] err_cnt;

  logic       s_x_in, s_x_valid, s_sync, s_par_mode, s_err_clr;
  logic       s_odd_out, s_frame_done, s_par_err, s_frame_par;
  logic [0:0] s_bit_idx;
  logic [1:0] s_err_cnt;

  int vec_count;
  int miss_count;

  parity_frame_checker #(.DATA_BITS(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .sync(sync),
    .par_mode(par_mode), .err_clr(err_clr), .odd_out(odd_out),
    .bit_idx(bit_idx), .frame_done(frame_done), .par_err(par_err),
    .frame_par(frame_par), .err_cnt(err_cnt)
  );

  parity_frame_checker #(.DATA_BITS(1), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .x_in(s_x_in), .x_valid(s_x_valid), .sync(s_sync),
    .par_mode(s_par_mode), .err_clr(s_err_clr), .odd_out(s_odd_out),
    .bit_idx(s_bit_idx), .frame_done(s_frame_done), .par_err(s_par_err),
    .frame_par(s_frame_par), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle into the 8-bit instance and return after the edge.
  task automatic applyStimulus(input logic xv, input logic xi, input logic sy,
                               input logic pm, input logic ec);
    x_valid  = xv;
    x_in     = xi;
    sync     = sy;
    par_mode = pm;
    err_clr  = ec;
    @(negedge clk);
    x_valid  = 1'b0;
    sync     = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic applySmallStimulus(input logic xv, input logic xi,
                                    input logic pm, input logic ec);
    s_x_valid  = xv;
    s_x_in     = xi;
    s_par_mode = pm;
    s_err_clr  = ec;
    @(negedge clk);
    s_x_valid  = 1'b0;
    s_err_clr  = 1'b0;
  endtask

  // Send eight data bits, MSB first, so the literal reads in arrival order.
  task automatic sendData(input logic [7:0] bits, input logic pm);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b0, pm, 1'b0);
  endtask

  task automatic checkFrame(input string tag, input logic done, input logic perr,
                            input logic fpar, input logic [7:0] cnt);
    checkOutput({tag, "_done"}, frame_done, done);
    checkOutput({tag, "_perr"}, par_err, perr);
    checkOutput({tag, "_fpar"}, frame_par, fpar);
    checkOutput({tag, "_cnt"},  err_cnt, cnt);
    checkOutput({tag, "_idx"},  bit_idx, 0);
    checkOutput({tag, "_odd"},  odd_out, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Running parity after each bit of 1,0,1,1,0,0,1,0.
  localparam logic [7:0] RUN_ODD = 8'b11011100;
  localparam logic [2:0] SAT_SEQ [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst = 1'b1;
    {x_in, x_valid, sync, par_mode, err_clr} = '0;
    {s_x_in, s_x_valid, s_sync, s_par_mode, s_err_clr} = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_idx", bit_idx, 0);
    checkOutput("rst_cnt", err_cnt, 0);
    checkOutput("rst_done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good odd-parity frame: four ones, parity bit 1.
    sendData(8'b10110010, 1'b1);
    checkOutput("t2_odd_pre", odd_out, 0);
    checkOutput("t2_idx_pre", bit_idx, 8);
    checkOutput("t2_done_pre", frame_done, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFrame("t2", 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_done_gone", frame_done, 0);

    // Same data, wrong parity bit in odd mode, then accepted in even mode.
    sendData(8'b10110010, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("t3_bad", 1'b1, 1'b1, 1'b0, 8'd1);
    sendData(8'b10110010, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFrame("t3_even", 1'b1, 1'b0, 1'b0, 8'd1);

    // Test 2 stream with three idle cycles after every data bit.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] bits;
      bits = 8'b10110010;
      applyStimulus(1'b1, bits[7-i], 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_gap_idx", bit_idx, i + 1);
        checkOutput("t4_gap_odd", odd_out, RUN_ODD[7-i]);
        checkOutput("t4_gap_done", frame_done, 0);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFrame("t4", 1'b1, 1'b0, 1'b0, 8'd1);

    // Partial frame of 1,1,1 discarded by sync together with a valid bit.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_idx_pre", bit_idx, 3);
    checkOutput("t5_odd_pre", odd_out, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_sync_idx", bit_idx, 0);
    checkOutput("t5_sync_odd", odd_out, 0);
    checkOutput("t5_sync_cnt", err_cnt, 1);
    sendData(8'b11100000, 1'b1);
    checkOutput("t5_odd_full", odd_out, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("t5", 1'b1, 1'b0, 1'b1, 8'd1);

    // sync in the parity slot wins: no frame reported, frame_par held.
    sendData(8'b10110010, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("syncpar_done", frame_done, 0);
    checkOutput("syncpar_perr", par_err, 0);
    checkOutput("syncpar_idx", bit_idx, 0);
    checkOutput("syncpar_fpar", frame_par, 1);
    checkOutput("syncpar_cnt", err_cnt, 1);

    // Asynchronous reset mid-frame, away from any clock edge.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_async_idx", bit_idx, 0);
    checkOutput("t1_async_odd", odd_out, 0);
    checkOutput("t1_async_fpar", frame_par, 0);
    checkOutput("t1_async_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_first_idx", bit_idx, 1);
    checkOutput("t1_first_odd", odd_out, 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_idx_par", bit_idx, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("t1", 1'b1, 1'b0, 1'b1, 8'd0);

    // Two-bit frames, 2-bit counter: back-to-back even-mode failures.
    for (int f = 0; f < 5; f++) begin
      applySmallStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_idx_mid", s_bit_idx, 1);
      applySmallStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_perr", s_par_err, 1);
      checkOutput("t6_cnt", s_err_cnt, SAT_SEQ[f]);
      checkOutput("t6_idx_end", s_bit_idx, 0);
    end
    applySmallStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_clr", s_err_cnt, 0);
    applySmallStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applySmallStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_clr_err_done", s_frame_done, 1);
    checkOutput("t6_clr_err_cnt", s_err_cnt, 1);
    applySmallStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applySmallStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_good_perr", s_par_err, 0);
    checkOutput("t6_good_fpar", s_frame_par, 1);
    checkOutput("t6_good_cnt", s_err_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
